msi_cache_controller: RTL and testbench

//  MSI snooping controller that sequences one cache_block line (state/tag/data storage).

---
 rtl/msi_pkg.sv | 28 ++
 rtl/msi_cache_controller.sv | 217 +++++++++++++++++++++
 tb/tb_msi_cache_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msi_pkg.sv
// Shared encodings for the MSI snooping cache controller.
package msi_pkg;

    // Coherence state of the single cache line (2'b11 is never written).
    typedef enum logic [1:0] {
        LineI = 2'b00,
        LineS = 2'b01,
        LineM = 2'b10
    } line_state_e;

    // Snoop bus command encoding, shared by bus_cmd and snoop_cmd.
    typedef enum logic [1:0] {
        CmdNone   = 2'd0,
        CmdRdMiss = 2'd1,
        CmdWrMiss = 2'd2,
        CmdInval  = 2'd3
    } bus_cmd_e;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StResp,
        StWb,
        StBus,
        StFill
    } ctrl_state_e;

endpackage

// File: rtl/msi_cache_controller.sv
// MSI snooping controller for one cache line: serves CPU reads/writes, issues bus
// transactions on misses and S-line writes, and answers snoops from other caches.
module msi_cache_controller
    import msi_pkg::*;
#(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    // cache_block interface
    input  logic [1:0]        line_state,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [DATA_W-1:0] line_data,
    output logic              line_write,
    output logic [1:0]        line_state_o,
    output logic [ADDR_W-1:0] line_addr_o,
    output logic [DATA_W-1:0] line_data_o,
    // bus request / command
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    // fill data
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    // writeback
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    // snoop input
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_cmd,
    input  logic [ADDR_W-1:0] snoop_addr
);

    ctrl_state_e       fsm_q, fsm_d;
    // Holds hit-read data for the response cycle, or fill data deferred by a snoop.
    logic [DATA_W-1:0] data_q, data_d;
    logic              held_q, held_d;

    logic              hit;
    logic              snoop_hit;
    logic              snoop_upd;
    logic [1:0]        grant_cmd;
    logic [DATA_W-1:0] fill_data;

    assign hit = (line_state != LineI) && (line_addr == cpu_addr);

    // Our own grant cycle owns the bus, so no other cache's command can be visible then.
    assign snoop_hit = snoop_valid && !bus_grant && (line_state != LineI)
                       && (snoop_addr == line_addr);

    // RD_MISS on an S line needs no action; everything else that hits rewrites the line.
    assign snoop_upd = snoop_hit && ((snoop_cmd == CmdWrMiss) || (snoop_cmd == CmdInval)
                       || ((snoop_cmd == CmdRdMiss) && (line_state == LineM)));

    // Command is chosen at grant time so snoops seen while waiting are accounted for.
    assign grant_cmd = (hit && cpu_we) ? CmdInval : (cpu_we ? CmdWrMiss : CmdRdMiss);

    assign fill_data = held_q ? data_q : mem_rdata;

    // Next-state and output decode; snoop updates take priority over CPU line updates.
    always_comb begin
        fsm_d        = fsm_q;
        data_d       = data_q;
        held_d       = held_q;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        line_write   = 1'b0;
        line_state_o = LineI;
        line_addr_o  = '0;
        line_data_o  = '0;
        bus_req      = 1'b0;
        bus_cmd      = CmdNone;
        bus_addr     = '0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;

        if (snoop_upd) begin
            line_write   = 1'b1;
            line_addr_o  = line_addr;
            line_data_o  = line_data;
            line_state_o = (snoop_cmd == CmdRdMiss) ? LineS : LineI;
            if (line_state == LineM) begin
                wb_valid = 1'b1;
                wb_addr  = line_addr;
                wb_data  = line_data;
            end
        end

        unique case (fsm_q)
            StIdle: begin
                // A snooped update this cycle defers the CPU decision to the next cycle.
                if (cpu_req && !snoop_upd) begin
                    if (hit && !cpu_we) begin
                        data_d = line_data;
                        fsm_d  = StResp;
                    end else if (hit && (line_state == LineM)) begin
                        line_write   = 1'b1;
                        line_state_o = LineM;
                        line_addr_o  = cpu_addr;
                        line_data_o  = cpu_wdata;
                        fsm_d        = StResp;
                    end else if (hit) begin
                        fsm_d = StBus;
                    end else if (line_state == LineM) begin
                        fsm_d = StWb;
                    end else begin
                        fsm_d = StBus;
                    end
                end
            end
            StResp: begin
                cpu_ready = 1'b1;
                cpu_rdata = data_q;
                fsm_d     = StIdle;
            end
            StWb: begin
                if (snoop_upd) begin
                    fsm_d = StIdle;
                end else begin
                    wb_valid     = 1'b1;
                    wb_addr      = line_addr;
                    wb_data      = line_data;
                    line_write   = 1'b1;
                    line_state_o = LineI;
                    line_addr_o  = line_addr;
                    line_data_o  = line_data;
                    fsm_d        = StBus;
                end
            end
            StBus: begin
                bus_req  = 1'b1;
                bus_addr = cpu_addr;
                if (bus_grant) begin
                    bus_cmd = grant_cmd;
                    if (grant_cmd == CmdInval) begin
                        line_write   = 1'b1;
                        line_state_o = LineM;
                        line_addr_o  = cpu_addr;
                        line_data_o  = cpu_wdata;
                        cpu_ready    = 1'b1;
                        fsm_d        = StIdle;
                    end else begin
                        held_d = 1'b0;
                        fsm_d  = StFill;
                    end
                end
            end
            StFill: begin
                if (held_q || mem_ready) begin
                    if (snoop_upd) begin
                        // Keep the fill data; the line update retries next cycle.
                        if (!held_q) begin
                            data_d = mem_rdata;
                            held_d = 1'b1;
                        end
                    end else begin
                        line_write   = 1'b1;
                        line_addr_o  = cpu_addr;
                        line_state_o = cpu_we ? LineM : LineS;
                        line_data_o  = cpu_we ? cpu_wdata : fill_data;
                        cpu_ready    = 1'b1;
                        cpu_rdata    = cpu_we ? '0 : fill_data;
                        held_d       = 1'b0;
                        fsm_d        = StIdle;
                    end
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase

        // Reset abandons any transaction and invalidates the line without writeback.
        if (reset) begin
            fsm_d        = StIdle;
            data_d       = '0;
            held_d       = 1'b0;
            cpu_ready    = 1'b0;
            cpu_rdata    = '0;
            line_write   = 1'b1;
            line_state_o = LineI;
            line_addr_o  = '0;
            line_data_o  = '0;
            bus_req      = 1'b0;
            bus_cmd      = CmdNone;
            bus_addr     = '0;
            wb_valid     = 1'b0;
            wb_addr      = '0;
            wb_data      = '0;
        end
    end

    // State and data-hold registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q  <= StIdle;
            data_q <= '0;
            held_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            held_q <= held_d;
        end
    end

endmodule

// File: tb/tb_msi_cache_controller.sv
// Self-checking bench for msi_cache_controller with a behavioural cache_block model.
module tb_msi_cache_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [2:0] cpu_addr = '0;
    logic [3:0] cpu_wdata = '0;
    logic       cpu_ready;
    logic [3:0] cpu_rdata;
    logic [1:0] line_state;
    logic [2:0] line_addr;
    logic [3:0] line_data;
    logic       line_write;
    logic [1:0] line_state_o;
    logic [2:0] line_addr_o;
    logic [3:0] line_data_o;
    logic       bus_req;
    logic       bus_grant = 1'b0;
    logic [1:0] bus_cmd;
    logic [2:0] bus_addr;
    logic       mem_ready = 1'b0;
    logic [3:0] mem_rdata = '0;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [3:0] wb_data;
    logic       snoop_valid = 1'b0;
    logic [1:0] snoop_cmd = '0;
    logic [2:0] snoop_addr = '0;

    // cache_block model, or direct line values while the snoop table runs
    logic       tbl_mode = 1'b0;
    logic [1:0] m_state = 2'b00;
    logic [2:0] m_addr = '0;
    logic [3:0] m_data = '0;
    logic [1:0] t_state = 2'b00;
    logic [2:0] t_addr = '0;
    logic [3:0] t_data = '0;

    int errors = 0;
    int checks = 0;

    assign line_state = tbl_mode ? t_state : m_state;
    assign line_addr  = tbl_mode ? t_addr : m_addr;
    assign line_data  = tbl_mode ? t_data : m_data;

    msi_cache_controller #(.ADDR_W(3), .DATA_W(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .line_state(line_state), .line_addr(line_addr), .line_data(line_data),
        .line_write(line_write), .line_state_o(line_state_o), .line_addr_o(line_addr_o),
        .line_data_o(line_data_o),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr)
    );

    always #5 clock = ~clock;

    // cache_block: capture the controller's write strobe
    always @(posedge clock) begin
        if (!tbl_mode && line_write) begin
            m_state <= line_state_o;
            m_addr  <= line_addr_o;
            m_data  <= line_data_o;
        end
    end

    typedef struct {
        logic [1:0] st;
        logic [2:0] la;
        logic [3:0] ld;
        logic       sv;
        logic [1:0] sc;
        logic [2:0] sa;
        logic       gr;
        logic       exp_lw;
        logic [1:0] exp_so;
        logic       exp_wb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start of a cycle: one-cycle stimulus returns to idle.
    task automatic cyc();
        @(negedge clock);
        bus_grant   = 1'b0;
        mem_ready   = 1'b0;
        snoop_valid = 1'b0;
        snoop_cmd   = 2'd0;
    endtask

    task automatic start_req(input logic we, input logic [2:0] addr, input logic [3:0] wd);
        cyc();
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        #1;
    endtask

    task automatic finish_req();
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
    endtask

    // Wait (bounded) for bus_req, grant it and check the command; grant stays up
    // through the sample point so the caller can check the grant cycle further.
    task automatic do_bus(input string name, input logic [1:0] cmd, input logic [2:0] addr);
        bit seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cyc();
            #1;
            if (bus_req) begin
                seen = 1'b1;
                bus_grant = 1'b1;
                #1;
                chk({name, "_bus_cmd"}, 32'(bus_cmd), 32'(cmd));
                chk({name, "_bus_addr"}, 32'(bus_addr), 32'(addr));
            end
        end
        if (!seen) chk({name, "_bus_req_timeout"}, 32'(bus_req), 32'd1);
    endtask

    task automatic do_fill(input string name, input logic we, input logic [3:0] rd,
                           input logic [2:0] addr, input logic [3:0] exp_data);
        cyc();
        mem_ready = 1'b1;
        mem_rdata = rd;
        #1;
        chk({name, "_fill_ready"}, 32'(cpu_ready), 32'd1);
        chk({name, "_fill_line"}, {line_write, line_state_o, line_addr_o, line_data_o},
            {1'b1, (we ? 2'b10 : 2'b01), addr, exp_data});
        if (!we) chk({name, "_fill_rdata"}, 32'(cpu_rdata), 32'(rd));
    endtask

    initial begin
        vec_t vecs[9];
        vecs[0] = '{2'b10, 3'd3, 4'h5, 1'b1, 2'd1, 3'd3, 1'b0, 1'b1, 2'b01, 1'b1};
        vecs[1] = '{2'b01, 3'd3, 4'h5, 1'b1, 2'd1, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[2] = '{2'b10, 3'd6, 4'hC, 1'b1, 2'd2, 3'd6, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[3] = '{2'b01, 3'd3, 4'h5, 1'b1, 2'd3, 3'd3, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[4] = '{2'b10, 3'd3, 4'h5, 1'b1, 2'd3, 3'd4, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[5] = '{2'b00, 3'd3, 4'h5, 1'b1, 2'd2, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{2'b10, 3'd3, 4'h5, 1'b1, 2'd1, 3'd3, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[7] = '{2'b10, 3'd3, 4'h5, 1'b0, 2'd2, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[8] = '{2'b10, 3'd3, 4'h5, 1'b1, 2'd0, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0};

        // Reset: outputs quiet, line invalidated
        @(negedge clock);
        #1;
        chk("reset_line_write", {line_write, line_state_o}, {1'b1, 2'b00});
        chk("reset_outputs", {cpu_ready, bus_req, bus_cmd, wb_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("idle_outputs", {line_write, cpu_ready, bus_req, wb_valid}, 32'd0);

        // Snoop response table (FSM idle, no CPU request)
        tbl_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            t_state     = vecs[i].st;
            t_addr      = vecs[i].la;
            t_data      = vecs[i].ld;
            snoop_valid = vecs[i].sv;
            snoop_cmd   = vecs[i].sc;
            snoop_addr  = vecs[i].sa;
            bus_grant   = vecs[i].gr;
            #1;
            chk($sformatf("snoop_vec%0d", i),
                {line_write, line_state_o, wb_valid, wb_addr, wb_data},
                {vecs[i].exp_lw, vecs[i].exp_so, vecs[i].exp_wb,
                 (vecs[i].exp_wb ? vecs[i].la : 3'd0), (vecs[i].exp_wb ? vecs[i].ld : 4'd0)});
        end
        cyc();
        tbl_mode = 1'b0;

        // 1: read miss addr 3, fill A
        start_req(1'b0, 3'd3, 4'h0);
        do_bus("t1", 2'd1, 3'd3);
        do_fill("t1", 1'b0, 4'hA, 3'd3, 4'hA);
        finish_req();
        chk("t1_model", {m_state, m_addr, m_data}, {2'b01, 3'd3, 4'hA});

        // 2: read hit, response next cycle, no bus traffic
        start_req(1'b0, 3'd3, 4'h0);
        chk("t2_not_yet", {cpu_ready, bus_req}, 32'd0);
        cyc();
        #1;
        chk("t2_hit", {cpu_ready, cpu_rdata, bus_req}, {1'b1, 4'hA, 1'b0});
        finish_req();

        // 3: write to S line -> INVAL, line M
        start_req(1'b1, 3'd3, 4'h5);
        do_bus("t3", 2'd3, 3'd3);
        chk("t3_inval_done", {cpu_ready, line_write, line_state_o, line_data_o},
            {1'b1, 1'b1, 2'b10, 4'h5});
        finish_req();
        chk("t3_model", {m_state, m_addr, m_data}, {2'b10, 3'd3, 4'h5});

        // 4: read miss on M victim -> writeback, then RD_MISS 6
        start_req(1'b0, 3'd6, 4'h0);
        cyc();
        #1;
        chk("t4_wb", {wb_valid, wb_addr, wb_data, line_write, line_state_o},
            {1'b1, 3'd3, 4'h5, 1'b1, 2'b00});
        do_bus("t4", 2'd1, 3'd6);
        do_fill("t4", 1'b0, 4'h7, 3'd6, 4'h7);
        finish_req();
        // write miss with S victim: no writeback, line becomes M 3/5
        start_req(1'b1, 3'd3, 4'h5);
        chk("t4b_no_wb", 32'(wb_valid), 32'd0);
        do_bus("t4b", 2'd2, 3'd3);
        do_fill("t4b", 1'b1, 4'hE, 3'd3, 4'h5);
        finish_req();
        chk("t4b_model", {m_state, m_addr, m_data}, {2'b10, 3'd3, 4'h5});

        // 5: snoop RD_MISS on M then INVAL
        cyc();
        snoop_valid = 1'b1;
        snoop_cmd   = 2'd1;
        snoop_addr  = 3'd3;
        #1;
        chk("t5_rd_snoop", {wb_valid, wb_addr, wb_data, line_write, line_state_o},
            {1'b1, 3'd3, 4'h5, 1'b1, 2'b01});
        cyc();
        snoop_valid = 1'b1;
        snoop_cmd   = 2'd3;
        snoop_addr  = 3'd3;
        #1;
        chk("t5_inval_snoop", {wb_valid, line_write, line_state_o}, {1'b0, 1'b1, 2'b00});
        @(posedge clock);
        #1;
        chk("t5_model", 32'(m_state), 32'd0);

        // 6: S line addr 2, CPU write collides with snoop WR_MISS -> write miss
        start_req(1'b0, 3'd2, 4'h0);
        do_bus("t6a", 2'd1, 3'd2);
        do_fill("t6a", 1'b0, 4'h9, 3'd2, 4'h9);
        finish_req();
        cyc();
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 3'd2;
        cpu_wdata   = 4'hC;
        snoop_valid = 1'b1;
        snoop_cmd   = 2'd2;
        snoop_addr  = 3'd2;
        #1;
        chk("t6_collide", {line_write, line_state_o, wb_valid, cpu_ready},
            {1'b1, 2'b00, 1'b0, 1'b0});
        do_bus("t6", 2'd2, 3'd2);
        do_fill("t6", 1'b1, 4'h0, 3'd2, 4'hC);
        finish_req();
        chk("t6_model", {m_state, m_addr, m_data}, {2'b10, 3'd2, 4'hC});

        // 7: reset during writeback -> no writeback, line invalidated
        start_req(1'b0, 3'd5, 4'h0);
        cyc();
        reset = 1'b1;
        #1;
        chk("t7_reset_mid", {wb_valid, bus_req, line_write, line_state_o},
            {1'b0, 1'b0, 1'b1, 2'b00});
        cyc();
        reset   = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("t7_after", {bus_req, line_write, wb_valid, cpu_ready}, 32'd0);
        chk("t7_model", 32'(m_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
